pulse_tally: RTL
================

PULSE_TALLY -- requirements
Module: pulse_tally

Interface
Parameters (name, default, meaning):
REQ-001 SCAN_DIV, 65536, clk cycles each display digit stays selected; legal range 2..2^24.
Ports (name  direction  width  meaning):
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 cnt_in  input  1  event level from the upstream button-conditioning FSM (its cnt output), same clock domain; each 0->1 transition is one event.
REQ-005 clr  input  1  synchronous clear of the tally, active-high.
REQ-006 value  output  16  registered BCD tally, value[15:12] thousands ... value[3:0] units.
REQ-007 ovf  output  1  registered one-cycle pulse on wrap 9999->0000.
REQ-008 seg  output  7  active-low segments, seg[6:0] = g,f,e,d,c,b,a.
REQ-009 an  output  4  active-low digit select, one-hot-zero; an[0] = units.

Function
REQ-010 cnt_in SHALL be registered into cnt_q every cycle; event = cnt_in & ~cnt_q.
REQ-011 On the clk edge at which event is 1, value SHALL increment by one in decimal (units 9 -> 0 with carry into next digit); zero-cycle latency from that edge, i.e. new value visible right after it.
REQ-012 Held-high cnt_in SHALL count exactly once; minimum event spacing is 2 cycles (1,0,1 pattern counts twice).
REQ-013 Increment from 9999 SHALL give 0000 and ovf=1 for exactly that one following cycle; ovf=0 otherwise.
REQ-014 clr=1 SHALL set value to 0000 at that edge and ovf to 0; clr has priority over a simultaneous event, which is discarded (cnt_q still updates).
REQ-015 Every BCD digit SHALL stay within 0..9 at all times.
REQ-016 A prescaler SHALL count 0..SCAN_DIV-1; at SCAN_DIV-1 it returns to 0 and digit index idx (2 bits) advances 0->1->2->3->0.
REQ-017 an SHALL be combinational from idx: idx0=1110, idx1=1101, idx2=1011, idx3=0111; exactly one bit low always.
REQ-018 seg SHALL be combinational decode of value digit selected by idx: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-019 Scan SHALL run independent of counting and clr; clr does not reset prescaler or idx.
REQ-020 No handshake back to upstream; events are never stalled or queued.

Reset
REQ-021 rst=1 at an edge SHALL give: value=0000, ovf=0, cnt_q=1, prescaler=0, idx=0 (an=1110, seg=1000000).
REQ-022 rst SHALL override clr and event; cnt_q=1 after reset ensures cnt_in high at reset release is not counted until it falls and rises again.
REQ-023 rst mid-scan or mid-count SHALL take effect at that same edge with no residual state.

Configuration
REQ-024 Macro PULSE_TALLY_BLANK_EN: when defined, digit at position i>0 SHALL show seg=1111111 if it and all higher digits are 0 (leading-zero blanking); units digit never blanked; an unchanged.
REQ-025 Without PULSE_TALLY_BLANK_EN all four digits SHALL always be decoded per REQ-018; value, ovf, an identical in both builds.

Verification (SCAN_DIV=4 in bench)
REQ-026 rst 2 cycles, cnt_in=1 held at release -> value stays 0000 until cnt_in 0 then 1, then 0001.
REQ-027 20 pulses of cnt_in (3 high, 2 low cycles each) -> value=0x0020, ovf never 1.
REQ-028 Preload via 9999 events, one more event -> value=0x0000, ovf=1 for exactly one cycle.
REQ-029 value=0x0042, clr=1 same cycle as a rising cnt_in -> value=0x0000, event not counted.
REQ-030 value=0x1234, watch 16 cycles -> an sequence 1110,1101,1011,0111 each 4 cycles, seg shows 4,3,2,1.
REQ-031 PULSE_TALLY_BLANK_EN defined, value=0x0007 -> idx1..3 seg=1111111, idx0 seg=1111000; value=0x0000 -> only units shows 1000000.

Source files
------------

// File: rtl/pulse_tally.sv
// pulse_tally: four-digit BCD event tally with multiplexed 7-segment scan.
// Leading-zero blanking is enabled by defining PULSE_TALLY_BLANK_EN.
//
// Ports:
//   clk     input   1   system clock, rising edge
//   rst     input   1   synchronous active-high reset
//   cnt_in  input   1   event level; each 0->1 transition counts once
//   clr     input   1   synchronous clear of the tally (rst has priority)
//   value   output 16   registered BCD tally, value[3:0] = units
//   ovf     output  1   registered one-cycle pulse on wrap 9999 -> 0000
//   seg     output  7   active-low segments {g,f,e,d,c,b,a}, decoded from idx
//   an      output  4   active-low one-hot digit select, an[0] = units
module pulse_tally #(
  parameter int unsigned SCAN_DIV = 65536
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cnt_in,
  input  logic        clr,
  output logic [15:0] value,
  output logic        ovf,
  output logic [6:0]  seg,
  output logic [3:0]  an
);

  localparam int unsigned PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);

  logic          cnt_q;
  logic          evt;
  logic [15:0]   value_inc;
  logic          wrap;
  logic [PW-1:0] presc;
  logic [1:0]    idx;
  logic [3:0]    digit;
  logic          blank;

  // Seven-segment decode, active low {g,f,e,d,c,b,a}; non-BCD codes go dark
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = 7'b1000000;
      4'd1:    seg_decode = 7'b1111001;
      4'd2:    seg_decode = 7'b0100100;
      4'd3:    seg_decode = 7'b0110000;
      4'd4:    seg_decode = 7'b0011001;
      4'd5:    seg_decode = 7'b0010010;
      4'd6:    seg_decode = 7'b0000010;
      4'd7:    seg_decode = 7'b1111000;
      4'd8:    seg_decode = 7'b0000000;
      4'd9:    seg_decode = 7'b0010000;
      default: seg_decode = 7'b1111111;
    endcase
  endfunction

  // Rising-edge detect; cnt_q resets high so a level held through reset is ignored
  assign evt = cnt_in & ~cnt_q;

  // Decimal +1 with ripple carry; carry out of the thousands digit is the wrap
  always_comb begin
    logic carry;
    value_inc = value;
    carry     = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (value[4*i +: 4] >= 4'd9) begin
          value_inc[4*i +: 4] = 4'd0;
        end else begin
          value_inc[4*i +: 4] = value[4*i +: 4] + 4'd1;
          carry               = 1'b0;
        end
      end
    end
    wrap = carry;
  end

  // Tally and overflow pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 1'b1;
      value <= 16'h0000;
      ovf   <= 1'b0;
    end else begin
      cnt_q <= cnt_in;
      if (clr) begin
        value <= 16'h0000;
        ovf   <= 1'b0;
      end else if (evt) begin
        value <= value_inc;
        ovf   <= wrap;
      end else begin
        ovf   <= 1'b0;
      end
    end
  end

  // Scan prescaler and digit index; free-running, unaffected by clr
  always_ff @(posedge clk) begin
    if (rst) begin
      presc <= '0;
      idx   <= 2'd0;
    end else if (presc == PRESC_LAST) begin
      presc <= '0;
      idx   <= idx + 2'd1;
    end else begin
      presc <= presc + PW'(1);
    end
  end

  // Digit select and blanking of leading zeros (units never blanked)
  always_comb begin
    digit = 4'd0;
    blank = 1'b0;
    case (idx)
      2'd0: digit = value[3:0];
      2'd1: digit = value[7:4];
      2'd2: digit = value[11:8];
      default: digit = value[15:12];
    endcase
`ifdef PULSE_TALLY_BLANK_EN
    case (idx)
      2'd1:    blank = (value[15:4] == 12'h000);
      2'd2:    blank = (value[15:8] == 8'h00);
      2'd3:    blank = (value[15:12] == 4'h0);
      default: blank = 1'b0;
    endcase
`endif
  end

  assign seg = blank ? 7'b1111111 : seg_decode(digit);
  assign an  = ~(4'b0001 << idx);

endmodule
